// File: rtl/uart_pkg.sv
// Constants and TX state encoding shared by uart_output and the matching uart_input receiver.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 4;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_MSB_FIRST    = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with push/pop, full/empty and show-ahead read data.
// Used by the UART transmitter and equally usable on the receive side.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused even when a pop frees a slot this cycle.
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_output.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1/8N2 frames on a registered txd.
// txd is registered from the current state, so the line trails the FSM by one clock.
module uart_output
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = UART_MSB_FIRST,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam bit               MSB       = (MSB_FIRST != 0);

    tx_state_t  state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shifter;
    logic [7:0] fifo_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       bit_end;
    logic       cur_bit;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_valid),
        .push_data(tx_data),
        .pop      (pop),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state != TX_IDLE) || !fifo_empty;
    assign bit_end  = (clk_cnt == LAST_CLK);
    assign cur_bit  = MSB ? shifter[7] : shifter[0];

    // Pop in IDLE, or on the final clock of the last stop bit so frames run back to back.
    assign pop = !fifo_empty &&
                 ((state == TX_IDLE) ||
                  (state == TX_STOP && bit_end && bit_cnt == LAST_STOP));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shifter <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shifter <= fifo_data;
                        clk_cnt <= '0;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    txd <= 1'b0;
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= TX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    txd <= cur_bit;
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shifter <= MSB ? {shifter[6:0], 1'b0} : {1'b0, shifter[7:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= TX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shifter <= fifo_data;
                                state   <= TX_START;
                            end else begin
                                state   <= TX_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule
